display_scan_ctrl: RTL and testbench
====================================

// Module: display_scan_ctrl
// PURPOSE
//  Time-multiplexes one shared BCD->7-seg decoder across N common-anode digits.
//  Steps through the digits and drives the decoder's 4-bit BCD input.
//  Registers the decoder's active-low segment output and drives one active-low anode per slot.
//  A blanking guard between slots prevents ghosting. Sits between the counter/BCD datapath and the board display pins.
// PARAMETERS
//  N_DIGITS      4      number of digits scanned (>=2)
//  REFRESH_DIV   50000  clk cycles per digit slot (> BLANK_CYCLES)
//  BLANK_CYCLES  16     cycles at slot start with all anodes off (>=2)
// PORTS
//  clk         in   1            system clock, single clock domain
//  rst         in   1            synchronous reset, active-high
//  en          in   1            1 = scan; 0 = display dark, scan reset
//  digits_in   in   4*N_DIGITS   BCD digits, [3:0] = digit 0 (LSD)
//  dp_in       in   N_DIGITS     decimal point per digit, 1 = lit
//  lz_blank    in   1            1 = suppress leading zeros
//  bcd_sel     out  4            BCD code to shared decoder
//  seg_in      in   7            decoder output, active-low, combinational from bcd_sel
//  seg_out     out  7            segments to pins, active-low
//  dp_out      out  1            decimal point to pins, active-low
//  an_out      out  N_DIGITS     anodes, active-low one-hot
//  frame_tick  out  1            1-cycle pulse at last cycle of each full frame
// BEHAVIOUR
//  - Reset/idle values: bcd_sel=0, seg_out=7'b1111111, dp_out=1, an_out=all 1, frame_tick=0, state=IDLE.
//  - FSM states:
//    - IDLE: while rst or !en; en=1 -> BLANK, digit idx=0, slot cnt=0 next cycle.
//    - BLANK: cnt 0..BLANK_CYCLES-1; an_out all 1, seg_out blank.
//      - cnt=0: bcd_sel <= snapshot[idx]; decoder settles during the remaining BLANK cycles.
//      - cnt=BLANK_CYCLES-1 -> SHOW.
//    - SHOW: cnt BLANK_CYCLES..REFRESH_DIV-1.
//      - seg_out <= seg_in; dp_out <= ~dp_snap[idx]; an_out[idx]=0, others 1.
//      - at cnt=REFRESH_DIV-1: cnt<=0, idx<=idx+1, wrapping N_DIGITS-1 -> 0; -> BLANK.
//  - Snapshot: digits_in, dp_in and lz_blank are captured on the cycle entering BLANK with idx=0
//    (from IDLE or on frame wrap). Mid-frame input changes take effect next frame only (no tearing).
//  - Leading-zero suppression, when the lz_blank snapshot = 1:
//    - digits from N_DIGITS-1 downward with value 0 are suppressed, up to the first nonzero digit.
//    - digit 0 is never suppressed.
//    - a suppressed slot keeps an_out all 1 and seg_out blank for the full slot; its dp is also suppressed.
//  - BCD codes >9 are passed to the decoder unchanged; seg_out shows whatever seg_in returns.
//  - frame_tick=1 exactly on cycle idx=N_DIGITS-1, cnt=REFRESH_DIV-1.
//  - en deassert in any state: IDLE next cycle, outputs at idle values next cycle.
//  - rst dominates en, with the same response.
//  - At most one anode is low on any cycle; an anode is never low during BLANK.
//  - Slot counter width $clog2(REFRESH_DIV); idx width $clog2(N_DIGITS); no other arithmetic.
// STRUCTURE
//  - Package disp_pkg:
//    - typedef enum logic[1:0] {IDLE, BLANK, SHOW} scan_state_t;
//    - localparam SEG_OFF = 7'b1111111; localparam AN_OFF_BIT = 1'b1.
//  - Sub-module display_slot_timer:
//    - params REFRESH_DIV, BLANK_CYCLES; ports clk, rst, run.
//    - outputs cnt, in_show, slot_end.
//  - Main FSM, snapshot and LZ mask (combinational from snapshot) live in this module.
// TESTING (N_DIGITS=4, REFRESH_DIV=8, BLANK_CYCLES=2)
//  1 Reset: rst=1 for 3 clk -> an_out=4'b1111, seg_out=7'h7F, dp_out=1, bcd_sel=0, frame_tick=0.
//  2 Scan order: en=1, digits_in=16'h1234, lz_blank=0 -> bcd_sel 4,3,2,1 per 8-cycle slot;
//    an_out 1110,1101,1011,0111 each low 6 cycles after 2 blank cycles; frame_tick once per 32 cycles.
//  3 Leading zeros: digits_in=16'h0050, lz_blank=1 -> digits 3,2 dark all slot; digits 1,0 shown.
//    digits_in=16'h0000 -> only digit 0 lit.
//  4 Tearing: change digits_in 16'h1234 -> 16'h9876 during digit-1 slot -> rest of frame still 3,2,1;
//    next frame bcd_sel 6,7,8,9.
//  5 Enable/reset mid-SHOW: en=0 (or rst=1) at cnt=4 of digit 2 -> next cycle an_out=4'b1111,
//    seg_out=7'h7F; re-enable -> restarts at digit 0 BLANK.
//  6 DP/invalid: dp_in=4'b0100, digit 0 = 4'hC -> dp_out=0 only in digit-2 SHOW; seg_out=seg_in
//    (decoder default 7'h7F) for digit 0.

Source files
------------

// File: rtl/display_scan_ctrl_pkg.sv
// Shared types and constants for the multiplexed 7-segment scan controller.
package disp_pkg;

  typedef enum logic [1:0] {IDLE, BLANK, SHOW} scan_state_t;

  localparam logic [6:0] SEG_OFF    = 7'b1111111;
  localparam logic       AN_OFF_BIT = 1'b1;

endpackage

// File: rtl/display_slot_timer.sv
// Per-digit slot counter: counts 0..REFRESH_DIV-1 while run is high, parks at 0 otherwise.
// in_show marks the post-blanking part of the slot; slot_end marks its last cycle.
module display_slot_timer
  import disp_pkg::*;
#(
  parameter int unsigned REFRESH_DIV  = 50000,
  parameter int unsigned BLANK_CYCLES = 16,
  localparam int unsigned CW          = $clog2(REFRESH_DIV)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          run,
  output logic [CW-1:0] cnt,
  output logic          in_show,
  output logic          slot_end
);

  localparam logic [CW-1:0] CNT_LAST   = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0] SHOW_FIRST = CW'(BLANK_CYCLES);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (!run) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt      = cnt_q;
  assign in_show  = (cnt_q >= SHOW_FIRST);
  assign slot_end = (cnt_q == CNT_LAST);

endmodule

// File: rtl/display_scan_ctrl.sv
// Scans N common-anode digits through one shared BCD->7-seg decoder with a blanking guard per slot.
// Segment/anode/dp outputs are registered one cycle after the state decision; frame_tick is combinational.
module display_scan_ctrl
  import disp_pkg::*;
#(
  parameter int unsigned N_DIGITS     = 4,
  parameter int unsigned REFRESH_DIV  = 50000,
  parameter int unsigned BLANK_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [4*N_DIGITS-1:0] digits_in,
  input  logic [N_DIGITS-1:0]   dp_in,
  input  logic                  lz_blank,
  output logic [3:0]            bcd_sel,
  input  logic [6:0]            seg_in,
  output logic [6:0]            seg_out,
  output logic                  dp_out,
  output logic [N_DIGITS-1:0]   an_out,
  output logic                  frame_tick
);

  localparam int unsigned IW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam int unsigned CW = $clog2(REFRESH_DIV);

  localparam logic [IW-1:0]       IDX_LAST   = IW'(N_DIGITS - 1);
  localparam logic [CW-1:0]       BLANK_LAST = CW'(BLANK_CYCLES - 1);
  localparam logic [N_DIGITS-1:0] AN_ALL_OFF = {N_DIGITS{AN_OFF_BIT}};

  scan_state_t           state_q, state_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [4*N_DIGITS-1:0] snap_dig_q, snap_dig_d;
  logic [N_DIGITS-1:0]   snap_dp_q, snap_dp_d;
  logic                  snap_lz_q, snap_lz_d;
  logic [3:0]            bcd_q, bcd_d;
  logic [6:0]            seg_q, seg_d;
  logic                  dp_q, dp_d;
  logic [N_DIGITS-1:0]   an_q, an_d;

  logic                  active;
  logic                  run;
  logic [CW-1:0]         cnt;
  logic                  in_show;
  logic                  slot_end;
  logic                  show_end;
  logic                  frame_start;
  logic [N_DIGITS-1:0]   supp;
  logic                  zero_run;
  logic [3:0]            cur_digit;
  logic                  cur_dp;
  logic                  cur_supp;
  logic [N_DIGITS-1:0]   an_sel;

  assign active = en & ~rst;
  assign run    = active & (state_q != IDLE);

  display_slot_timer #(
    .REFRESH_DIV  (REFRESH_DIV),
    .BLANK_CYCLES (BLANK_CYCLES)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .run      (run),
    .cnt      (cnt),
    .in_show  (in_show),
    .slot_end (slot_end)
  );

  assign show_end    = (state_q == SHOW) & in_show & slot_end;
  // Inputs are latched only when a frame begins, so a frame never mixes old and new digits.
  assign frame_start = active & ((state_q == IDLE) | (show_end & (idx_q == IDX_LAST)));

  // Zero digits from the top down are dark until the first nonzero one; digit 0 always shows.
  always_comb begin
    supp     = '0;
    zero_run = 1'b1;
    for (int i = N_DIGITS - 1; i >= 1; i--) begin
      zero_run = zero_run & (snap_dig_q[4*i +: 4] == 4'd0);
      supp[i]  = snap_lz_q & zero_run;
    end
  end

  always_comb begin
    cur_digit = '0;
    cur_dp    = 1'b0;
    cur_supp  = 1'b0;
    an_sel    = AN_ALL_OFF;
    for (int i = 0; i < N_DIGITS; i++) begin
      if (idx_q == IW'(i)) begin
        cur_digit = snap_dig_q[4*i +: 4];
        cur_dp    = snap_dp_q[i];
        cur_supp  = supp[i];
        an_sel[i] = ~AN_OFF_BIT;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      snap_dig_q <= '0;
      snap_dp_q  <= '0;
      snap_lz_q  <= 1'b0;
      bcd_q      <= '0;
      seg_q      <= SEG_OFF;
      dp_q       <= 1'b1;
      an_q       <= AN_ALL_OFF;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      snap_dig_q <= snap_dig_d;
      snap_dp_q  <= snap_dp_d;
      snap_lz_q  <= snap_lz_d;
      bcd_q      <= bcd_d;
      seg_q      <= seg_d;
      dp_q       <= dp_d;
      an_q       <= an_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    snap_dig_d = snap_dig_q;
    snap_dp_d  = snap_dp_q;
    snap_lz_d  = snap_lz_q;
    unique case (state_q)
      IDLE: begin
        idx_d = '0;
        if (active) state_d = BLANK;
      end
      BLANK: begin
        if (cnt == BLANK_LAST) state_d = SHOW;
      end
      SHOW: begin
        if (show_end) begin
          state_d = BLANK;
          idx_d   = (idx_q == IDX_LAST) ? '0 : idx_q + IW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    if (frame_start) begin
      snap_dig_d = digits_in;
      snap_dp_d  = dp_in;
      snap_lz_d  = lz_blank;
    end
    if (!active) begin
      state_d = IDLE;
      idx_d   = '0;
    end
  end

  // Outputs are registered from the next state so anodes and segments switch on the same edge.
  always_comb begin
    bcd_d = bcd_q;
    seg_d = SEG_OFF;
    dp_d  = 1'b1;
    an_d  = AN_ALL_OFF;
    if (state_d == IDLE) begin
      bcd_d = '0;
    end else if ((state_q == BLANK) && (cnt == '0)) begin
      bcd_d = cur_digit;
    end
    if ((state_d == SHOW) && !cur_supp) begin
      seg_d = seg_in;
      dp_d  = ~cur_dp;
      an_d  = an_sel;
    end
  end

  assign frame_tick = show_end & (idx_q == IDX_LAST);
  assign bcd_sel    = bcd_q;
  assign seg_out    = seg_q;
  assign dp_out     = dp_q;
  assign an_out     = an_q;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Directed bench for display_scan_ctrl with N_DIGITS=4, REFRESH_DIV=8, BLANK_CYCLES=2.
module tb_display_scan_ctrl;

  logic        clk;
  logic        rst;
  logic        en;
  logic [15:0] digits_in;
  logic [3:0]  dp_in;
  logic        lz_blank;
  logic [3:0]  bcd_sel;
  logic [6:0]  seg_in;
  logic [6:0]  seg_out;
  logic        dp_out;
  logic [3:0]  an_out;
  logic        frame_tick;

  int checks = 0;
  int errors = 0;

  display_scan_ctrl #(
    .N_DIGITS     (4),
    .REFRESH_DIV  (8),
    .BLANK_CYCLES (2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .digits_in  (digits_in),
    .dp_in      (dp_in),
    .lz_blank   (lz_blank),
    .bcd_sel    (bcd_sel),
    .seg_in     (seg_in),
    .seg_out    (seg_out),
    .dp_out     (dp_out),
    .an_out     (an_out),
    .frame_tick (frame_tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Board decoder model: active-low gfedcba, anything above 9 is dark.
  function automatic logic [6:0] dec(input logic [3:0] b);
    case (b)
      4'd0: dec = 7'h40;
      4'd1: dec = 7'h79;
      4'd2: dec = 7'h24;
      4'd3: dec = 7'h30;
      4'd4: dec = 7'h19;
      4'd5: dec = 7'h12;
      4'd6: dec = 7'h02;
      4'd7: dec = 7'h78;
      4'd8: dec = 7'h00;
      4'd9: dec = 7'h10;
      default: dec = 7'h7F;
    endcase
  endfunction

  always_comb seg_in = dec(bcd_sel);

  typedef struct packed {
    logic [15:0] dig;
    logic [3:0]  dp;
    logic        lz;
    logic [15:0] bcd;   // per slot, slot 0 in [3:0]
    logic [15:0] an;    // anode pattern during SHOW, slot 0 in [3:0]
    logic [27:0] seg;   // seg_out during SHOW, slot 0 in [6:0]
    logic [3:0]  dpo;   // dp_out during SHOW, slot 0 in [0]
  } vec_t;

  vec_t vecs [5];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, " an"},   32'(an_out),     32'hF);
    chk({tag, " seg"},  32'(seg_out),    32'h7F);
    chk({tag, " dp"},   32'(dp_out),     32'h1);
    chk({tag, " bcd"},  32'(bcd_sel),    32'h0);
    chk({tag, " tick"}, 32'(frame_tick), 32'h0);
  endtask

  task automatic run_vec(input int v);
    int s;
    int c;
    @(negedge clk);
    digits_in = vecs[v].dig;
    dp_in     = vecs[v].dp;
    lz_blank  = vecs[v].lz;
    en        = 1'b1;
    for (int k = 0; k < 32; k++) begin
      @(negedge clk);
      s = k / 8;
      c = k % 8;
      if (c == 1) begin
        chk($sformatf("v%0d s%0d bcd", v, s), 32'(bcd_sel), 32'(vecs[v].bcd[4*s +: 4]));
        chk($sformatf("v%0d s%0d blank an", v, s), 32'(an_out), 32'hF);
        chk($sformatf("v%0d s%0d blank seg", v, s), 32'(seg_out), 32'h7F);
      end
      if (c == 5) begin
        chk($sformatf("v%0d s%0d an", v, s), 32'(an_out), 32'(vecs[v].an[4*s +: 4]));
        chk($sformatf("v%0d s%0d seg", v, s), 32'(seg_out), 32'(vecs[v].seg[7*s +: 7]));
        chk($sformatf("v%0d s%0d dp", v, s), 32'(dp_out), 32'(vecs[v].dpo[s]));
      end
      if (c == 7) begin
        chk($sformatf("v%0d s%0d tick", v, s), 32'(frame_tick), (s == 3) ? 32'h1 : 32'h0);
      end
    end
    en = 1'b0;
    @(negedge clk);
    chk_idle($sformatf("v%0d stop", v));
  endtask

  task automatic tearing_seq();
    logic [31:0] exp_bcd;
    int s;
    int c;
    exp_bcd = 32'h9876_1234;
    @(negedge clk);
    digits_in = 16'h1234;
    dp_in     = 4'b0000;
    lz_blank  = 1'b0;
    en        = 1'b1;
    for (int k = 0; k < 64; k++) begin
      @(negedge clk);
      s = k / 8;
      c = k % 8;
      if (c == 1) chk($sformatf("tear slot%0d bcd", s), 32'(bcd_sel), 32'(exp_bcd[4*s +: 4]));
      if (c == 7) chk($sformatf("tear slot%0d tick", s), 32'(frame_tick), ((s % 4) == 3) ? 32'h1 : 32'h0);
      if (k == 11) digits_in = 16'h9876;
    end
    en = 1'b0;
    @(negedge clk);
    chk_idle("tear stop");
  endtask

  task automatic drop_seq(input bit use_rst);
    string tag;
    tag = use_rst ? "rst drop" : "en drop";
    @(negedge clk);
    digits_in = 16'h1234;
    dp_in     = 4'b0000;
    lz_blank  = 1'b0;
    en        = 1'b1;
    for (int k = 0; k <= 20; k++) @(negedge clk);
    chk({tag, " pre an"}, 32'(an_out), 32'hB);
    if (use_rst) rst = 1'b1;
    else en = 1'b0;
    @(negedge clk);
    chk_idle(tag);
    rst = 1'b0;
    en  = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (k == 0) chk({tag, " restart blank an"}, 32'(an_out), 32'hF);
      if (k == 1) chk({tag, " restart bcd"}, 32'(bcd_sel), 32'h4);
      if (k == 5) begin
        chk({tag, " restart an"}, 32'(an_out), 32'hE);
        chk({tag, " restart seg"}, 32'(seg_out), 32'h19);
      end
    end
    en = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{dig: 16'h1234, dp: 4'b0000, lz: 1'b0, bcd: 16'h1234, an: 16'h7BDE,
                seg: {7'h79, 7'h24, 7'h30, 7'h19}, dpo: 4'b1111};
    vecs[1] = '{dig: 16'h0050, dp: 4'b0000, lz: 1'b1, bcd: 16'h0050, an: 16'hFFDE,
                seg: {7'h7F, 7'h7F, 7'h12, 7'h40}, dpo: 4'b1111};
    vecs[2] = '{dig: 16'h0000, dp: 4'b1111, lz: 1'b1, bcd: 16'h0000, an: 16'hFFFE,
                seg: {7'h7F, 7'h7F, 7'h7F, 7'h40}, dpo: 4'b1110};
    vecs[3] = '{dig: 16'h123C, dp: 4'b0100, lz: 1'b0, bcd: 16'h123C, an: 16'h7BDE,
                seg: {7'h79, 7'h24, 7'h30, 7'h7F}, dpo: 4'b1011};
    vecs[4] = '{dig: 16'h0905, dp: 4'b0000, lz: 1'b1, bcd: 16'h0905, an: 16'hFBDE,
                seg: {7'h7F, 7'h10, 7'h40, 7'h12}, dpo: 4'b1111};

    rst       = 1'b1;
    en        = 1'b0;
    digits_in = 16'h0000;
    dp_in     = 4'b0000;
    lz_blank  = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_idle("reset");
    rst = 1'b0;

    for (int v = 0; v < 5; v++) run_vec(v);
    tearing_seq();
    drop_seq(1'b0);
    drop_seq(1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
